vga_sync_gen: RTL

- Consumes the 25 MHz pixel-enable pulse from the clock-divider stage and generates 640x480@60 VGA timing.
- Produces hsync, vsync, the video_on blanking qualifier, pixel coordinates, and line/frame boundary strobes for the downstream pixel/colour logic.
- Operates in the system clk domain, advancing one pixel per clk cycle in which pix_en is high.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/sync_axis_counter.sv | 78 +++++++
 rtl/vga_sync_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants,
// per-axis phase enum and counter width.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D  = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D  = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 33;

  localparam int MAX_TOTAL = 1 << CNT_W;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

endpackage

// File: rtl/sync_axis_counter.sv
// sync_axis_counter: one timing axis (count + phase FSM).
// Ports: clk, reset (async, active-low), adv (advance strobe),
//        cnt (current count), phase (region of cnt),
//        wrap (cnt is last of axis), active, sync.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_D,
  parameter int FRONT  = H_FRONT_D,
  parameter int SYNC   = H_SYNC_D,
  parameter int BACK   = H_BACK_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  // Last count of each region; the phase moves on
  // when an advance happens at one of these.
  localparam logic [CNT_W-1:0] A_END =
    CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] F_END =
    CNT_W'(ACTIVE + FRONT - 1);
  localparam logic [CNT_W-1:0] S_END =
    CNT_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL - 1);

  phase_t phase_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= PH_ACTIVE;
    end else begin
      phase <= phase_nx;
    end
  end

  always_comb begin
    phase_nx = phase;
    if (adv) begin
      unique case (phase)
        PH_ACTIVE:
          if (cnt == A_END) phase_nx = PH_FRONT;
        PH_FRONT:
          if (cnt == F_END) phase_nx = PH_SYNC;
        PH_SYNC:
          if (cnt == S_END) phase_nx = PH_BACK;
        PH_BACK:
          if (cnt == LAST) phase_nx = PH_ACTIVE;
        default:
          phase_nx = PH_ACTIVE;
      endcase
    end
  end

  always_comb begin
    wrap   = (cnt == LAST);
    active = (phase == PH_ACTIVE);
    sync   = (phase == PH_SYNC);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA sync/blanking/coordinate generator.
// Ports: clk, reset (async, active-low), pix_en (pixel advance),
//        hsync, vsync, video_on, px_x, px_y,
//        line_end, frame_end (one-clk strobes).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FRONT  = H_FRONT_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BACK   = H_BACK_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FRONT  = V_FRONT_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BACK   = V_BACK_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL)
  begin : g_bad_total
    $error("vga_sync_gen: line/frame total exceeds 1024");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  phase_t           h_phase;
  phase_t           v_phase;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_act;
  logic             v_act;
  logic             h_sync;
  logic             v_sync;
  logic             v_adv;

  // Lines advance on the pixel that ends the line.
  assign v_adv = pix_en && h_wrap;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .adv    (pix_en),
    .cnt    (h_cnt),
    .phase  (h_phase),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (h_sync)
  );

  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .adv    (v_adv),
    .cnt    (v_cnt),
    .phase  (v_phase),
    .wrap   (v_wrap),
    .active (v_act),
    .sync   (v_sync)
  );

  // Outputs present the position held by the counters
  // before this advance, so they trail by one pix_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      video_on  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      if (pix_en) begin
        hsync     <= h_sync ? SYNC_POL : ~SYNC_POL;
        vsync     <= v_sync ? SYNC_POL : ~SYNC_POL;
        video_on  <= h_act && v_act;
        px_x      <= h_cnt;
        px_y      <= v_cnt;
        line_end  <= h_wrap && (h_phase == PH_BACK);
        frame_end <= h_wrap && v_wrap &&
                     (v_phase == PH_BACK);
      end
    end
  end

endmodule
